// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared types and defaults for the multiplier arbiter
package mult_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_RESP,
        ST_DRAIN
    } state_t;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_OP_WIDTH       = 64;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    localparam int CNT_W = cnt_width(DEF_TIMEOUT_CYCLES);

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter int NumReq = 4,
    parameter int PtrW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] req,
    input  logic [PtrW-1:0]   ptr,
    output logic [NumReq-1:0] grant,
    output logic              valid
);

    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            int idx;
            idx = int'(ptr) + i;
            if (idx >= NumReq) idx = idx - NumReq;
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin sharing of one multiplier accelerator
// with a WAIT timeout and a DRAIN phase for late completions.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NumReq        = DEF_NUM_REQ,
    parameter int OpWidth       = DEF_OP_WIDTH,
    parameter int TimeoutCycles = DEF_TIMEOUT_CYCLES
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NumReq-1:0]         req_i,
    input  logic [NumReq*OpWidth-1:0] a_i,
    input  logic [NumReq*OpWidth-1:0] b_i,
    output logic [NumReq-1:0]         gnt_o,
    output logic [NumReq-1:0]         rsp_valid_o,
    output logic [2*OpWidth-1:0]      rsp_data_o,
    output logic                      rsp_err_o,
    output logic                      busy_o,
    output logic                      acc_start_o,
    output logic [OpWidth-1:0]        acc_a_o,
    output logic [OpWidth-1:0]        acc_b_o,
    input  logic                      acc_done_i,
    input  logic [2*OpWidth-1:0]      acc_result_i
);

    localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int CntW = cnt_width(TimeoutCycles);

    state_t              r_state;
    logic [PtrW-1:0]     r_ptr;
    logic [CntW-1:0]     r_cnt;
    logic [NumReq-1:0]   r_winner;
    logic [NumReq-1:0]   r_gnt;
    logic [NumReq-1:0]   r_rsp_valid;
    logic [2*OpWidth-1:0] r_rsp_data;
    logic                r_rsp_err;
    logic                r_acc_start;
    logic [OpWidth-1:0]  r_acc_a;
    logic [OpWidth-1:0]  r_acc_b;

    logic [NumReq-1:0]   w_grant;
    logic                w_grant_valid;
    logic [OpWidth-1:0]  w_sel_a;
    logic [OpWidth-1:0]  w_sel_b;
    logic [PtrW-1:0]     w_ptr_next;

    rr_arbiter #(
        .NumReq (NumReq),
        .PtrW   (PtrW)
    ) u_rr_arbiter (
        .req   (req_i),
        .ptr   (r_ptr),
        .grant (w_grant),
        .valid (w_grant_valid)
    );

    // One-hot grant selects the winner's operand slices and the next search start.
    always_comb begin
        w_sel_a    = '0;
        w_sel_b    = '0;
        w_ptr_next = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (w_grant[k]) begin
                w_sel_a    = w_sel_a | a_i[k*OpWidth +: OpWidth];
                w_sel_b    = w_sel_b | b_i[k*OpWidth +: OpWidth];
                w_ptr_next = (k == NumReq - 1) ? '0 : PtrW'(k + 1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_winner    <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_acc_start <= 1'b0;
            r_acc_a     <= '0;
            r_acc_b     <= '0;
        end else begin
            r_gnt       <= '0;
            r_acc_start <= 1'b0;
            r_rsp_valid <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_winner    <= w_grant;
                        r_gnt       <= w_grant;
                        r_acc_start <= 1'b1;
                        r_acc_a     <= w_sel_a;
                        r_acc_b     <= w_sel_b;
                        r_ptr       <= w_ptr_next;
                        r_state     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion wins over a timeout landing in the same cycle.
                    if (acc_done_i) begin
                        r_rsp_data  <= acc_result_i;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= r_winner;
                        r_state     <= ST_RESP;
                    end else if (r_cnt == CntW'(TimeoutCycles - 1)) begin
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= r_winner;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                ST_RESP: begin
                    r_state    <= r_rsp_err ? ST_DRAIN : ST_IDLE;
                    r_rsp_data <= '0;
                    r_rsp_err  <= 1'b0;
                end
                ST_DRAIN: begin
                    if (acc_done_i) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt_o       = r_gnt;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_data_o  = r_rsp_data;
    assign rsp_err_o   = r_rsp_err;
    assign busy_o      = (r_state != ST_IDLE);
    assign acc_start_o = r_acc_start;
    assign acc_a_o     = r_acc_a;
    assign acc_b_o     = r_acc_b;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - scoreboard bench for mult_arbiter
module tb_mult_arbiter;

    localparam int NR = 4;
    localparam int OW = 64;
    localparam int TO = 8;

    typedef struct {
        logic [NR-1:0]   v;
        logic [2*OW-1:0] d;
        logic            e;
    } rsp_t;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic [NR-1:0]     req_i = '0;
    logic [NR*OW-1:0]  a_i = '0;
    logic [NR*OW-1:0]  b_i = '0;
    logic [NR-1:0]     gnt_o;
    logic [NR-1:0]     rsp_valid_o;
    logic [2*OW-1:0]   rsp_data_o;
    logic              rsp_err_o;
    logic              busy_o;
    logic              acc_start_o;
    logic [OW-1:0]     acc_a_o;
    logic [OW-1:0]     acc_b_o;
    logic              acc_done_i = 1'b0;
    logic [2*OW-1:0]   acc_result_i = '0;

    int total = 0;
    int bad   = 0;

    logic [NR-1:0] exp_gnt[$];
    rsp_t          exp_rsp[$];
    logic [NR-1:0] mon_g;
    rsp_t          mon_r;

    mult_arbiter #(
        .NumReq        (NR),
        .OpWidth       (OW),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .gnt_o        (gnt_o),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_data_o   (rsp_data_o),
        .rsp_err_o    (rsp_err_o),
        .busy_o       (busy_o),
        .acc_start_o  (acc_start_o),
        .acc_a_o      (acc_a_o),
        .acc_b_o      (acc_b_o),
        .acc_done_i   (acc_done_i),
        .acc_result_i (acc_result_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [2*OW-1:0] act, input logic [2*OW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, gnt_o, 0);
        check({tag, "_rsp_valid"}, rsp_valid_o, 0);
        check({tag, "_rsp_data"}, rsp_data_o, 0);
        check({tag, "_rsp_err"}, rsp_err_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_start"}, acc_start_o, 0);
        check({tag, "_acc_a"}, acc_a_o, 0);
        check({tag, "_acc_b"}, acc_b_o, 0);
    endtask

    task automatic set_operands(input int win, input logic [OW-1:0] a, input logic [OW-1:0] b);
        for (int k = 0; k < NR; k++) begin
            a_i[k*OW +: OW] = (k == win) ? a : (64'hA5A5_A5A5_0000_0000 | 64'(k));
            b_i[k*OW +: OW] = (k == win) ? b : (64'h5A5A_5A5A_0000_0000 | 64'(k));
        end
    endtask

    // Called one step after an edge with the DUT in IDLE; returns one step after it is back in IDLE.
    task automatic do_op(input logic [NR-1:0] req, input int win, input logic [OW-1:0] a,
                         input logic [OW-1:0] b, input int n_wait, input bit hold, input bit tmo);
        logic [2*OW-1:0] prod;
        logic [NR-1:0]   one;
        rsp_t            r;
        prod = {64'b0, a} * {64'b0, b};
        one  = 4'b0001 << win;
        set_operands(win, a, b);
        req_i = req;
        exp_gnt.push_back(one);
        r.v = one;
        r.d = tmo ? '0 : prod;
        r.e = tmo;
        exp_rsp.push_back(r);
        tick;
        check("launch_gnt", gnt_o, one);
        check("launch_start", acc_start_o, 1);
        check("launch_acc_a", acc_a_o, a);
        check("launch_acc_b", acc_b_o, b);
        check("launch_busy", busy_o, 1);
        if (!hold) req_i = '0;
        tick;
        check("wait_start_low", acc_start_o, 0);
        check("wait_gnt_low", gnt_o, 0);
        if (tmo) begin
            repeat (TO) tick;
            check("tmo_rsp_valid", rsp_valid_o, one);
            tick;
            req_i = 4'b0100;
            repeat (4) begin
                check("drain_busy", busy_o, 1);
                check("drain_no_start", acc_start_o, 0);
                check("drain_no_gnt", gnt_o, 0);
                tick;
            end
            req_i        = '0;
            acc_done_i   = 1'b1;
            acc_result_i = '1;
            tick;
            acc_done_i   = 1'b0;
            acc_result_i = '0;
            check("drain_exit_idle", busy_o, 0);
        end else begin
            repeat (n_wait - 1) tick;
            check("wait_hold_a", acc_a_o, a);
            check("wait_hold_b", acc_b_o, b);
            acc_done_i   = 1'b1;
            acc_result_i = prod;
            tick;
            acc_done_i   = 1'b0;
            acc_result_i = 128'hDEAD_BEEF;
            check("resp_valid", rsp_valid_o, one);
            tick;
            check("resp_to_idle", busy_o, 0);
            check("idle_rsp_clear", rsp_valid_o, 0);
        end
    endtask

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (gnt_o != '0) begin
                if (exp_gnt.size() == 0) begin
                    check("gnt_unexpected", gnt_o, 0);
                end else begin
                    mon_g = exp_gnt.pop_front();
                    check("sb_gnt", gnt_o, mon_g);
                end
            end
            if (rsp_valid_o != '0) begin
                if (exp_rsp.size() == 0) begin
                    check("rsp_unexpected", rsp_valid_o, 0);
                end else begin
                    mon_r = exp_rsp.pop_front();
                    check("sb_rsp_valid", rsp_valid_o, mon_r.v);
                    check("sb_rsp_data", rsp_data_o, mon_r.d);
                    check("sb_rsp_err", rsp_err_o, mon_r.e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        repeat (2) tick;
        check_all_zero("reset");
        rst_i = 1'b0;
        tick;

        do_op(4'b0010, 1, 64'd3, 64'd5, 6, 1'b0, 1'b0);

        rst_i = 1'b1;
        tick;
        rst_i = 1'b0;
        tick;

        do_op(4'b1111, 0, 64'd2, 64'd10, 2, 1'b1, 1'b0);
        do_op(4'b1111, 1, 64'd3, 64'd11, 2, 1'b1, 1'b0);
        do_op(4'b1111, 2, 64'd4, 64'd12, 2, 1'b1, 1'b0);
        do_op(4'b1111, 3, 64'd5, 64'd13, 2, 1'b1, 1'b0);
        do_op(4'b1111, 0, 64'd6, 64'd14, 2, 1'b1, 1'b0);
        req_i = '0;

        do_op(4'b0100, 2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3, 1'b0, 1'b0);

        do_op(4'b1001, 3, 64'd7, 64'd9, 1, 1'b1, 1'b0);
        do_op(4'b1001, 0, 64'd8, 64'd9, 1, 1'b1, 1'b0);
        req_i = '0;

        do_op(4'b0001, 0, 64'd7, 64'd9, 0, 1'b0, 1'b1);

        do_op(4'b0010, 1, 64'h1_0000_0000, 64'h3, TO, 1'b0, 1'b0);

        set_operands(3, 64'd11, 64'd13);
        req_i = 4'b1000;
        exp_gnt.push_back(4'b1000);
        tick;
        check("rstwait_gnt", gnt_o, 4'b1000);
        req_i = '0;
        repeat (3) tick;
        #2 rst_i = 1'b1;
        #1 check_all_zero("rst_async");
        tick;
        tick;
        rst_i = 1'b0;
        tick;
        acc_done_i   = 1'b1;
        acc_result_i = 128'd143;
        tick;
        acc_done_i   = 1'b0;
        acc_result_i = '0;
        tick;
        check_all_zero("late_done");
        tick;

        do_op(4'b1001, 0, 64'd12, 64'd12, 1, 1'b0, 1'b0);

        repeat (2) tick;
        check("exp_gnt_empty", exp_gnt.size(), 0);
        check("exp_rsp_empty", exp_rsp.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter NumReq, default 4: number of requesters sharing one multiplier accelerator.
REQ-002 Parameter OpWidth, default 64: operand width in bits.
REQ-003 Parameter TimeoutCycles, default 1024: maximum number of WAIT cycles before the operation is aborted.
REQ-004 Port clk_i, input, 1: single clock; all logic is on the rising edge.
REQ-005 Port rst_i, input, 1: asynchronous, active-high reset.
REQ-006 Port req_i, input, NumReq: per-requester request level.
REQ-007 Port a_i and b_i, input, NumReq*OpWidth each: operand slices; requester k uses bits [k*OpWidth +: OpWidth].
REQ-008 Port gnt_o, output, NumReq: one-hot, one-cycle pulse marking operand capture.
REQ-009 Port rsp_valid_o, output, NumReq: one-hot, one-cycle response pulse to the owning requester.
REQ-010 Port rsp_data_o, output, 2*OpWidth: product, valid only while rsp_valid_o is nonzero.
REQ-011 Port rsp_err_o, output, 1: timeout flag, qualified by rsp_valid_o.
REQ-012 Port busy_o, output, 1: high in every state except IDLE.
REQ-013 Port acc_start_o, output, 1: start pulse to the accelerator.
REQ-014 Port acc_a_o and acc_b_o, output, OpWidth each: captured operands sent to the accelerator.
REQ-015 Port acc_done_i, input, 1: accelerator completion pulse.
REQ-016 Port acc_result_i, input, 2*OpWidth: accelerator product, valid while acc_done_i is high.

Function
REQ-017 The FSM states SHALL be IDLE, LAUNCH, WAIT, RESP and DRAIN.
REQ-018 IDLE with req_i nonzero SHALL select one winner round-robin, register its operands, and go to LAUNCH; IDLE with req_i zero SHALL stay in IDLE.
REQ-019 Round-robin SHALL start the search at index ptr, wrap from NumReq-1 to 0, and set ptr to winner+1 (mod NumReq) on every grant; ptr resets to 0.
REQ-020 In LAUNCH, gnt_o[winner] and acc_start_o SHALL each be high for exactly one cycle, then the FSM goes to WAIT.
REQ-021 Grant latency SHALL be fixed: a request sampled in IDLE at edge t produces gnt_o during cycle t+1.
REQ-022 acc_a_o and acc_b_o SHALL hold the captured operands unchanged from LAUNCH until the FSM returns to IDLE.
REQ-023 req_i SHALL be ignored in every state except IDLE; a requester still holding req_i after its grant is re-arbitrated as a new request.
REQ-024 In WAIT, acc_done_i high SHALL register acc_result_i into rsp_data_o, clear rsp_err_o, and go to RESP.
REQ-025 WAIT SHALL count its cycles; when the count reaches TimeoutCycles-1 with no acc_done_i, the FSM SHALL set rsp_data_o to 0 and rsp_err_o to 1, and go to RESP.
REQ-026 If acc_done_i and timeout occur in the same cycle, done SHALL take priority.
REQ-027 RESP SHALL last one cycle with rsp_valid_o[winner] high.
REQ-028 After RESP, the FSM SHALL go to DRAIN if the operation timed out, otherwise to IDLE.
REQ-029 DRAIN SHALL wait for acc_done_i, discard the result, then go to IDLE; no new start is issued while the accelerator may still be busy.
REQ-030 acc_done_i SHALL be ignored in IDLE, LAUNCH and RESP.
REQ-031 At most one operation SHALL be outstanding at any time.
REQ-032 The result SHALL be passed through unmodified at 2*OpWidth bits; no truncation or sign handling.

Reset
REQ-033 rst_i high SHALL immediately force IDLE, ptr=0, counter=0 and all outputs to 0, including mid-operation.
REQ-034 After reset, a response for an aborted operation SHALL never be issued; a late acc_done_i is ignored in IDLE.

Structure
REQ-035 Package mult_arb_pkg SHALL hold the state enum, the default parameter values and the counter width, $clog2(TimeoutCycles).
REQ-036 Sub-module rr_arbiter (NumReq; inputs req and ptr; outputs one-hot grant and valid) SHALL be combinational and used once.

Verification
REQ-037 Single request: req_i=4'b0010, a=3, b=5, accelerator done after 6 WAIT cycles with result 15 -> gnt_o=0010 at t+1, rsp_valid_o=0010, rsp_data_o=15, rsp_err_o=0.
REQ-038 Contention: req_i=4'b1111 held, ptr=0 -> grant order 0,1,2,3,0 across successive operations.
REQ-039 Wrap: ptr=3, req_i=4'b1001 -> grant 3, then grant 0.
REQ-040 Timeout: TimeoutCycles=8, done withheld -> rsp_err_o=1 and rsp_data_o=0 after 8 WAIT cycles; FSM stays in DRAIN, busy_o=1, until done arrives.
REQ-041 Simultaneous events: done arrives exactly in the last WAIT cycle -> valid result, rsp_err_o=0, no DRAIN.
REQ-042 Reset in WAIT: rst_i pulsed, then late acc_done_i -> no rsp_valid_o, FSM in IDLE, all outputs 0.
